// File: rtl/pwm_regs.sv
// pwm_regs: byte-addressed configuration register file for the PWM generator.
// Sits behind the SPI instruction decoder; 16-bit registers commit atomically
// on the high-byte write, and the counter value is read through a high-byte
// snapshot taken when the low byte is read.
module pwm_regs #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_write,
    output logic [DATA_W-1:0]     data_read,
    input  logic [2*DATA_W-1:0]   counter_val,
    output logic [2*DATA_W-1:0]   period,
    output logic                  en,
    output logic [2*DATA_W-1:0]   compare1,
    output logic [2*DATA_W-1:0]   compare2,
    output logic                  count_reset,
    output logic [DATA_W-1:0]     prescale,
    output logic                  upnotdown,
    output logic                  pwm_en,
    output logic [1:0]            functions
);

    typedef enum logic [ADDR_W-1:0] {
        A_PERIOD_L  = ADDR_W'('h00),
        A_PERIOD_H  = ADDR_W'('h01),
        A_EN        = ADDR_W'('h02),
        A_CMP1_L    = ADDR_W'('h03),
        A_CMP1_H    = ADDR_W'('h04),
        A_CMP2_L    = ADDR_W'('h05),
        A_CMP2_H    = ADDR_W'('h06),
        A_CNT_RST   = ADDR_W'('h07),
        A_CNT_L     = ADDR_W'('h08),
        A_CNT_H     = ADDR_W'('h09),
        A_PRESCALE  = ADDR_W'('h0A),
        A_UPNOTDOWN = ADDR_W'('h0B),
        A_PWM_EN    = ADDR_W'('h0C),
        A_FUNCTIONS = ADDR_W'('h0D)
    } reg_addr_e;

    // Private low-byte staging per 16-bit register, plus the counter snapshot
    logic [DATA_W-1:0] period_stage;
    logic [DATA_W-1:0] cmp1_stage;
    logic [DATA_W-1:0] cmp2_stage;
    logic [DATA_W-1:0] cnt_snap;

    // Register writes: low bytes stage, high bytes commit {data, staging}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period       <= '0;
            compare1     <= '0;
            compare2     <= '0;
            period_stage <= '0;
            cmp1_stage   <= '0;
            cmp2_stage   <= '0;
            en           <= 1'b0;
            prescale     <= '0;
            upnotdown    <= 1'b1;
            pwm_en       <= 1'b0;
            functions    <= 2'b00;
        end else if (write) begin
            case (addr)
                A_PERIOD_L:  period_stage <= data_write;
                A_PERIOD_H:  period       <= {data_write, period_stage};
                A_EN:        en           <= data_write[0];
                A_CMP1_L:    cmp1_stage   <= data_write;
                A_CMP1_H:    compare1     <= {data_write, cmp1_stage};
                A_CMP2_L:    cmp2_stage   <= data_write;
                A_CMP2_H:    compare2     <= {data_write, cmp2_stage};
                A_PRESCALE:  prescale     <= data_write;
                A_UPNOTDOWN: upnotdown    <= data_write[0];
                A_PWM_EN:    pwm_en       <= data_write[0];
                A_FUNCTIONS: functions    <= data_write[1:0];
                default: ;
            endcase
        end
    end

    // Counter clear: one-cycle pulse following each COUNTER_RESET write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reset <= 1'b0;
        end else begin
            count_reset <= write && (addr == A_CNT_RST);
        end
    end

    // Snapshot of the counter high byte, taken when the low byte is read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_snap <= '0;
        end else if (read && (addr == A_CNT_L)) begin
            cnt_snap <= counter_val[2*DATA_W-1:DATA_W];
        end
    end

    // Combinational read mux; low-byte addresses return the committed byte
    always_comb begin
        data_read = '0;
        case (addr)
            A_PERIOD_L:  data_read = period[DATA_W-1:0];
            A_PERIOD_H:  data_read = period[2*DATA_W-1:DATA_W];
            A_EN:        data_read = {{(DATA_W-1){1'b0}}, en};
            A_CMP1_L:    data_read = compare1[DATA_W-1:0];
            A_CMP1_H:    data_read = compare1[2*DATA_W-1:DATA_W];
            A_CMP2_L:    data_read = compare2[DATA_W-1:0];
            A_CMP2_H:    data_read = compare2[2*DATA_W-1:DATA_W];
            A_CNT_L:     data_read = counter_val[DATA_W-1:0];
            A_CNT_H:     data_read = cnt_snap;
            A_PRESCALE:  data_read = prescale;
            A_UPNOTDOWN: data_read = {{(DATA_W-1){1'b0}}, upnotdown};
            A_PWM_EN:    data_read = {{(DATA_W-1){1'b0}}, pwm_en};
            A_FUNCTIONS: data_read = {{(DATA_W-2){1'b0}}, functions};
            default:     data_read = '0;
        endcase
    end

endmodule

// File: tb/tb_pwm_regs.sv
// tb_pwm_regs: directed scoreboard bench for pwm_regs.
// Stimulus queues (cycle, signal, expected) entries; a negedge monitor
// compares every entry due in the current cycle.
module tb_pwm_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read;
    logic        write;
    logic [5:0]  addr;
    logic [7:0]  data_write;
    logic [7:0]  data_read;
    logic [15:0] counter_val;
    logic [15:0] period;
    logic        en;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic        count_reset;
    logic [7:0]  prescale;
    logic        upnotdown;
    logic        pwm_en;
    logic [1:0]  functions;

    pwm_regs #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read        (read),
        .write       (write),
        .addr        (addr),
        .data_write  (data_write),
        .data_read   (data_read),
        .counter_val (counter_val),
        .period      (period),
        .en          (en),
        .compare1    (compare1),
        .compare2    (compare2),
        .count_reset (count_reset),
        .prescale    (prescale),
        .upnotdown   (upnotdown),
        .pwm_en      (pwm_en),
        .functions   (functions)
    );

    always #5 clk = ~clk;

    typedef enum int {S_RD, S_PER, S_CMP1, S_CMP2, S_CR, S_EN, S_PRE, S_UND, S_PWM, S_FN} sel_t;

    typedef struct {
        int unsigned cyc;
        sel_t        sel;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t        sb[$];
    chk_t        pend[$];
    chk_t        e;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] got;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] obs(input sel_t s);
        case (s)
            S_RD:    return {8'h00, data_read};
            S_PER:   return period;
            S_CMP1:  return compare1;
            S_CMP2:  return compare2;
            S_CR:    return {15'h0, count_reset};
            S_EN:    return {15'h0, en};
            S_PRE:   return {8'h00, prescale};
            S_UND:   return {15'h0, upnotdown};
            S_PWM:   return {15'h0, pwm_en};
            default: return {14'h0, functions};
        endcase
    endfunction

    // Monitor: compare every queued entry due this cycle, flag overdue ones
    always @(negedge clk) begin
        pend = {};
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.cyc == cyc) begin
                n_vec++;
                got = obs(e.sel);
                if (got !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                end
            end else if (e.cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: not sampled, expected %h", e.name, e.exp);
            end else begin
                pend.push_back(e);
            end
        end
        sb = pend;
    end

    task automatic expect_at(input int unsigned d, input sel_t s, input logic [15:0] v, input string nm);
        chk_t c;
        c.cyc  = cyc + d;
        c.sel  = s;
        c.exp  = v;
        c.name = nm;
        sb.push_back(c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        addr       = a;
        data_write = d;
        write      = 1'b1;
        @(posedge clk);
        #1;
        write      = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        addr        = '0;
        data_write  = '0;
        counter_val = 16'h0000;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Reset values of outputs
        expect_at(0, S_PER,  16'h0000, "rst_period");
        expect_at(0, S_CMP1, 16'h0000, "rst_cmp1");
        expect_at(0, S_CMP2, 16'h0000, "rst_cmp2");
        expect_at(0, S_EN,   16'h0000, "rst_en");
        expect_at(0, S_CR,   16'h0000, "rst_count_reset");
        expect_at(0, S_PRE,  16'h0000, "rst_prescale");
        expect_at(0, S_UND,  16'h0001, "rst_upnotdown");
        expect_at(0, S_PWM,  16'h0000, "rst_pwm_en");
        expect_at(0, S_FN,   16'h0000, "rst_functions");

        // Reset readback of every address 0x00-0x0F
        for (int i = 0; i < 16; i++) begin
            addr = 6'(i);
            expect_at(0, S_RD, (i == 11) ? 16'h0001 : 16'h0000, $sformatf("rst_rd_%0h", i));
            idle(1);
        end

        // Staged period write
        expect_at(1, S_PER, 16'h0000, "period_staged");
        wr(6'h00, 8'h34);
        expect_at(0, S_PER, 16'h0000, "period_pre_commit");
        expect_at(1, S_PER, 16'h1234, "period_commit");
        wr(6'h01, 8'h12);
        addr = 6'h00;
        expect_at(0, S_RD, 16'h0034, "period_l_rd");
        idle(1);

        // Independent staging for compare1/compare2
        wr(6'h03, 8'hAA);
        wr(6'h05, 8'h55);
        wr(6'h04, 8'h01);
        wr(6'h06, 8'h02);
        expect_at(0, S_CMP1, 16'h01AA, "cmp1_commit");
        expect_at(0, S_CMP2, 16'h0255, "cmp2_commit");
        wr(6'h04, 8'h07);
        expect_at(0, S_CMP1, 16'h07AA, "cmp1_high_only");
        wr(6'h03, 8'h11);
        addr = 6'h03;
        expect_at(0, S_RD,   16'h00AA, "cmp1_l_rd_committed");
        expect_at(0, S_CMP1, 16'h07AA, "cmp1_after_stage");
        idle(1);

        // Counter snapshot
        counter_val = 16'h12FF;
        addr = 6'h08;
        read = 1'b1;
        expect_at(0, S_RD, 16'h00FF, "cnt_l_rd");
        idle(1);
        read = 1'b0;
        counter_val = 16'h1300;
        addr = 6'h09;
        expect_at(0, S_RD, 16'h0012, "cnt_h_snapshot");
        idle(1);
        addr = 6'h08;
        expect_at(0, S_RD, 16'h0000, "cnt_l_live");
        idle(1);
        addr = 6'h09;
        expect_at(0, S_RD, 16'h0012, "cnt_h_no_resnap");
        idle(1);

        // Back-to-back counter reset pulses
        expect_at(0, S_CR, 16'h0000, "cr_before");
        expect_at(1, S_CR, 16'h0001, "cr_pulse1");
        expect_at(2, S_CR, 16'h0001, "cr_pulse2");
        expect_at(3, S_CR, 16'h0000, "cr_after");
        wr(6'h07, 8'h5A);
        wr(6'h07, 8'h5A);
        addr = 6'h07;
        expect_at(0, S_RD, 16'h0000, "cr_rd");
        idle(2);

        // Narrow fields, prescale, and ignored address
        wr(6'h0D, 8'hFF);
        wr(6'h02, 8'hFE);
        expect_at(0, S_FN, 16'h0003, "functions_wr");
        expect_at(0, S_EN, 16'h0000, "en_lsb0");
        addr = 6'h0D;
        expect_at(0, S_RD, 16'h0003, "functions_rd");
        idle(1);
        addr = 6'h02;
        expect_at(0, S_RD, 16'h0000, "en_rd");
        idle(1);
        wr(6'h0A, 8'hA5);
        wr(6'h0B, 8'hFE);
        wr(6'h0C, 8'h03);
        wr(6'h02, 8'h01);
        expect_at(0, S_PRE, 16'h00A5, "prescale_wr");
        expect_at(0, S_UND, 16'h0000, "upnotdown_wr");
        expect_at(0, S_PWM, 16'h0001, "pwm_en_wr");
        expect_at(0, S_EN,  16'h0001, "en_wr");
        addr = 6'h0C;
        expect_at(0, S_RD, 16'h0001, "pwm_en_rd");
        idle(1);
        wr(6'h3F, 8'h99);
        expect_at(0, S_PER,  16'h1234, "ign_period");
        expect_at(0, S_CMP1, 16'h07AA, "ign_cmp1");
        expect_at(0, S_CMP2, 16'h0255, "ign_cmp2");
        expect_at(0, S_PRE,  16'h00A5, "ign_prescale");
        expect_at(0, S_FN,   16'h0003, "ign_functions");
        expect_at(0, S_CR,   16'h0000, "ign_count_reset");
        addr = 6'h3F;
        expect_at(0, S_RD, 16'h0000, "ign_rd");
        idle(1);

        // Reset between low and high writes clears staging
        wr(6'h00, 8'h11);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        expect_at(0, S_PER, 16'h0000, "mid_rst_period");
        expect_at(0, S_UND, 16'h0001, "mid_rst_upnotdown");
        expect_at(1, S_PER, 16'h2200, "mid_rst_commit");
        wr(6'h01, 8'h22);
        idle(2);

        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d checks pending, required 0", sb.size());
            n_err = n_err + sb.size();
            n_vec = n_vec + sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
